// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch unit.
// Holds XLEN/RESET_PC defaults, PC step and entry layout.
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int PC_INCR = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Ports: clk, rst, push, pop, flush, wdata -> rdata, count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push && (cnt_q != FULL_C);
    do_pop  = pop && (cnt_q != '0);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // flush also swallows a same-cycle push
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata;
        wptr_d = wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: sequential PC, imem request port, prefetch queue.
// Ports: clk, rst, redirect*, imem_req_*, imem_rsp_*, out_*.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } q_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   outst;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] rsp_pc;
  q_entry_t        q_wdata;
  q_entry_t        q_rdata;
  logic            req_fire;
  logic            rsp_live;
  logic            pop_fire;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^redirect_addr[1:0];

  // credits: queued + in flight never exceeds DEPTH
  always_comb begin
    inflight = {1'b0, q_count} + {1'b0, outst};
    imem_req_valid = !rst && !redirect &&
                     (inflight < LIMIT_C);
    req_fire = imem_req_valid && imem_req_ready;
    rsp_live = imem_rsp_valid && (drop_q == '0);
    pop_fire = out_valid && out_ready;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_addr[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
    end
  end

  // everything still in flight after a redirect is stale
  always_comb begin
    drop_d = drop_q;
    if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (redirect) begin
      drop_d = outst - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // request-PC tracker: one entry per outstanding request,
  // popped by every response so it stays aligned with drops;
  // its occupancy is the outstanding count
  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (XLEN)
  ) u_pc_trk (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .wdata (fetch_pc_q),
    .rdata (rsp_pc),
    .count (outst)
  );

  assign q_wdata.pc    = rsp_pc;
  assign q_wdata.instr = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_live),
    .pop   (pop_fire),
    .flush (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign out_valid     = (q_count != '0);
  assign out_pc        = q_rdata.pc;
  assign out_instr     = q_rdata.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue.
// Memory model plus expected-stream reference.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_addr = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       pipe[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc;
  int          lat;
  int          pops;
  int          reqs;
  int          first_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic        vhist [0:4095];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_rsp();
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pipe[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // one clock cycle: sample mid-cycle, update model, advance
  task automatic step();
    #4;
    vhist[cyc % 4096] = out_valid;
    if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (imem_rsp_valid) void'(pipe.pop_front());
    if (redirect) begin
      vectors++;
      if (imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL req_on_redirect cyc=%0d got %b want 0",
                 cyc, imem_req_valid);
      end
    end
    if (out_valid === 1'b1 && out_ready) begin
      vectors++;
      if (out_pc !== exp_pc) begin
        miscompares++;
        $display("FAIL out_pc cyc=%0d got %h want %h",
                 cyc, out_pc, exp_pc);
      end
      vectors++;
      if (out_instr !== mem_word(exp_pc)) begin
        miscompares++;
        $display("FAIL out_instr cyc=%0d got %h want %h",
                 cyc, out_instr, mem_word(exp_pc));
      end
      exp_pc += 32'd4;
      pops++;
    end
    if (redirect) exp_pc = {redirect_addr[31:2], 2'b00};
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      vectors++;
      if (imem_req_addr !== exp_req) begin
        miscompares++;
        $display("FAIL req_addr cyc=%0d got %h want %h",
                 cyc, imem_req_addr, exp_req);
      end
      pipe.push_back('{imem_req_addr, cyc + lat});
      exp_req += 32'd4;
      reqs++;
    end
    if (redirect) exp_req = {redirect_addr[31:2], 2'b00};
    vectors++;
    if (pipe.size() > DEPTH) begin
      miscompares++;
      $display("FAIL credits cyc=%0d got %0d want <=%0d",
               cyc, pipe.size(), DEPTH);
    end
    @(posedge clk);
    cyc++;
    #1;
    drive_rsp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pipe.delete();
    exp_pc = 32'h0;
    exp_req = 32'h0;
    pops = 0;
    reqs = 0;
    first_valid = -1;
    cyc = 0;
    rst = 1'b0;
    drive_rsp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #4;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
    end
    vectors++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_out_data got %h/%h want 0/0",
               out_pc, out_instr);
    end
    do_reset();
    #2;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_req got %b/%h want 1/00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (12) step();
    vectors++;
    if (first_valid != 2) begin
      miscompares++;
      $display("FAIL stream_latency got %0d want 2", first_valid);
    end
    vectors++;
    if (pops != 10) begin
      miscompares++;
      $display("FAIL stream_throughput got %0d want 10", pops);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1) begin
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
            out_instr !== mem_word(32'h0)) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d got %b/%h want 1/0",
                   cyc, out_valid, out_pc);
        end
      end
    end
    #3;
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_req_valid got %b want 0", imem_req_valid);
    end
    vectors++;
    if (reqs != 4) begin
      miscompares++;
      $display("FAIL stall_req_count got %0d want 4", reqs);
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_addr = 32'h0000_0105;
    step();
    redirect = 1'b0;
    repeat (10) step();
    vectors++;
    if (first_valid != 7) begin
      miscompares++;
      $display("FAIL redir_first_valid got %0d want 7", first_valid);
    end
    vectors++;
    if (pops < 1) begin
      miscompares++;
      $display("FAIL redir_pops got %0d want >=1", pops);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    repeat (7) step();
    vectors++;
    if (pops != 5) begin
      miscompares++;
      $display("FAIL wrap_pops got %0d want 5", pops);
    end
  endtask

  task automatic test_collide();
    do_reset();
    lat = 2;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    redirect = 1'b1;
    redirect_addr = 32'h0000_0200;
    step();
    redirect = 1'b0;
    repeat (8) step();
    vectors++;
    if (vhist[6] !== 1'b1 || vhist[7] !== 1'b0 ||
        vhist[8] !== 1'b0 || vhist[9] !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_gap got %b%b%b%b want 1000",
               vhist[6], vhist[7], vhist[8], vhist[9]);
    end
    vectors++;
    if (vhist[10] !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_resume got %b want 1", vhist[10]);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        lat = 3;
      end
      imem_req_ready = $urandom_range(1, 0) == 1;
      out_ready = $urandom_range(3, 0) != 0;
      redirect = $urandom_range(19, 0) == 0;
      redirect_addr = $urandom;
      step();
    end
    redirect = 1'b0;
    vectors++;
    if (pops < 100) begin
      miscompares++;
      $display("FAIL random_progress got %0d want >=100", pops);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    lat = 1;
    pops = 0;
    reqs = 0;
    first_valid = -1;
    exp_pc = '0;
    exp_req = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_wrap();
    test_collide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
